add_share_arb: RTL and testbench
================================

ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 12, operand width; fixed to the shared adder width.
REQ-003 Parameter ID_W, default 2, requester-id width, equal to clog2(N_REQ).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-008 req_a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-009 req_b  in  N_REQ*W  operand B, same packing as req_a.
REQ-010 req_ready  out  N_REQ  one-hot or zero; high on the requester accepted this cycle.
REQ-011 res_valid  out  1  result FIFO head valid.
REQ-012 res_sum  out  W+1  head sum; MSB is carry-out.
REQ-013 res_id  out  ID_W  index of the requester that produced the head result.
REQ-014 res_ready  in  1  consumer accepts the head when res_valid is also high.
REQ-015 op_cnt  out  16  count of accepted requests; wraps from 0xFFFF to 0.

Function
REQ-016 A request transfers on req_valid[i] & req_ready[i]; a result transfers on res_valid & res_ready.
REQ-017 Arbitration SHALL be round-robin. Search starts at pointer rr_ptr and picks the first i with req_valid[i] set, in order rr_ptr, rr_ptr+1, ... (mod N_REQ).
REQ-018 On a grant to i, rr_ptr SHALL become (i+1) mod N_REQ; with no grant, rr_ptr is held.
REQ-019 At most one grant per cycle. req_ready[i] SHALL be combinational from req_valid, rr_ptr and FIFO state.
REQ-020 A grant SHALL occur only if the FIFO is not full, or it is full and a pop happens in the same cycle.
REQ-021 The granted operands SHALL drive the single adder instance combinationally. The adder's interleaved input bus SHALL be driven as bit 2k = a[k] and bit 2k+1 = b[k].
REQ-022 The adder outputs, with the granted id, SHALL be written into a 2-entry result FIFO at the same clock edge as the grant.
REQ-023 Latency: with the FIFO empty, res_valid SHALL rise the cycle after acceptance, with res_sum = a+b (W+1 bits).
REQ-024 With the FIFO empty, no bypass: a result is never presented in its own grant cycle.
REQ-025 Simultaneous push and pop SHALL keep the FIFO count unchanged and preserve FIFO order.
REQ-026 A full FIFO with res_ready low SHALL force every req_ready low; rr_ptr and op_cnt are held.
REQ-027 res_sum and res_id SHALL stay stable while res_valid is high and res_ready is low.
REQ-028 op_cnt SHALL increment by exactly 1 per accepted request.
REQ-029 A requester holding req_valid SHALL be granted within N_REQ grants (no starvation).

Reset
REQ-030 Reset values: rr_ptr=0, FIFO empty (res_valid=0), res_sum=0, res_id=0, op_cnt=0.
REQ-031 A mid-operation reset SHALL discard all buffered results immediately. No req_ready is high while rst is asserted.
REQ-032 The first grant SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 A shared package SHALL hold ADD_W=12, the result struct {sum[W:0], id[ID_W-1:0]} and FIFO_DEPTH=2.
REQ-034 One sub-module SHALL be used: the team's existing 12-bit Brent-Kung adder (module BrentKung), instantiated once. No other arithmetic SHALL be inferred for the sum.
REQ-035 The arbiter, FIFO and counter SHALL be inline logic in add_share_arb; target 150-300 lines.

Verification
REQ-036 Single request: req_valid=0001, a=0x0FF, b=0x001, FIFO empty -> req_ready=0001; next cycle res_valid=1, res_sum=0x0100, res_id=0, op_cnt=1.
REQ-037 Carry-out: a=0xFFF, b=0xFFF from requester 2 -> res_sum=0x1FFE, res_id=2.
REQ-038 Round-robin: all four valid continuously, res_ready=1, rr_ptr=0 -> grants to 0,1,2,3,0 in consecutive cycles; res_id sequence 0,1,2,3,0.
REQ-039 Backpressure: res_ready=0, requester 1 valid for 4 cycles -> exactly 2 grants, then req_ready=0. Raising res_ready for 1 cycle -> one pop and one grant in the same cycle, results in order.
REQ-040 Reset mid-stream: FIFO holding 2 entries, rst pulsed asynchronously between edges -> res_valid=0 and op_cnt=0 immediately; after release, a grant from requester 0 first.
REQ-041 Counter wrap: op_cnt preset to 0xFFFF by driving 65535 accepts, then one more accept -> op_cnt=0x0000.

Source files
------------

// File: rtl/add_share_arb_pkg.sv
// add_share_arb_pkg
// Shared constants and types for the shared-adder arbiter.
//   ADD_W      : width of the shared Brent-Kung adder operands
//   FIFO_DEPTH : number of buffered results
//   RES_ID_W   : stored requester-id width (enough for up to 8 requesters)
//   res_t      : one buffered result {sum, id}
package add_share_arb_pkg;

  localparam int ADD_W      = 12;
  localparam int FIFO_DEPTH = 2;
  localparam int RES_ID_W   = 3;

  typedef struct packed {
    logic [ADD_W:0]    sum;  // MSB is the carry-out
    logic [RES_ID_W-1:0] id;
  } res_t;

endpackage

// File: rtl/add_share_arb_brentkung.sv
// BrentKung
// 12-bit Brent-Kung parallel-prefix adder, carry-in fixed at zero.
// Ports:
//   ab  in  2*ADD_W  interleaved operands: bit 2k = a[k], bit 2k+1 = b[k]
//   sum out ADD_W+1  a + b, MSB is carry-out
module BrentKung
  import add_share_arb_pkg::*;
(
  input  logic [2*ADD_W-1:0] ab,
  output logic [ADD_W:0]     sum
);

  localparam int LEVELS = $clog2(ADD_W);

  logic [ADD_W-1:0] g0;
  logic [ADD_W-1:0] p0;
  logic [ADD_W-1:0] g_w;
  logic [ADD_W-1:0] p_w;
  logic [ADD_W-1:0] g_pre;
  logic [ADD_W:0]   carry;

  generate
    for (genvar gi = 0; gi < ADD_W; gi++) begin : gen_pg
      assign g0[gi] = ab[2*gi] & ab[2*gi+1];
      assign p0[gi] = ab[2*gi] ^ ab[2*gi+1];
    end
  endgenerate

  // Prefix tree, updated in place. Nodes at or above ADD_W are simply
  // absent; every node below ADD_W only ever depends on lower nodes.
  always_comb begin
    g_w = g0;
    p_w = p0;
    // Up-sweep: node i (i+1 a multiple of 2^(l+1)) absorbs node i-2^l.
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < ADD_W; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          g_w[i] = g_w[i] | (p_w[i] & g_w[i - (1 << l)]);
          p_w[i] = p_w[i] & p_w[i - (1 << l)];
        end
      end
    end
    // Down-sweep: fill in the remaining prefixes from the completed ones.
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 0; i < ADD_W; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= 3 * (1 << l) - 1)) begin
          g_w[i] = g_w[i] | (p_w[i] & g_w[i - (1 << l)]);
          p_w[i] = p_w[i] & p_w[i - (1 << l)];
        end
      end
    end
    g_pre = g_w;
  end

  assign carry = {g_pre, 1'b0};

  generate
    for (genvar gi = 0; gi < ADD_W; gi++) begin : gen_sum
      assign sum[gi] = p0[gi] ^ carry[gi];
    end
  endgenerate

  assign sum[ADD_W] = carry[ADD_W];

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb
// N_REQ requesters share one Brent-Kung adder through a round-robin
// arbiter; results queue in a 2-entry FIFO tagged with the requester id.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      packed operands, requester i at [i*W +: W]
//   res_valid/ready   result FIFO head handshake
//   res_sum, res_id   head sum (MSB carry-out) and producing requester
//   op_cnt            accepted-request counter, wraps at 16 bits
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 12,   // must equal ADD_W
  parameter int ID_W  = 2     // $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  output logic [W:0]         res_sum,
  output logic [ID_W-1:0]    res_id,
  input  logic               res_ready,
  output logic [15:0]        op_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  res_t             mem_reg [FIFO_DEPTH];
  logic [15:0]      op_cnt_reg;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             full;
  logic             pop;
  logic             grant;
  logic [W-1:0]     grant_a;
  logic [W-1:0]     grant_b;
  logic [2*W-1:0]   add_in;
  logic [W:0]       add_sum;
  res_t             head;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
      end
    end
  end

  assign res_valid = (count_reg != '0);
  assign full      = (count_reg == FULL_CNT);
  assign pop       = res_valid & res_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  // Gating with rst keeps every ready low during reset.
  assign grant     = grant_found & (~full | pop) & ~rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_ready
      assign req_ready[gi] = grant & (grant_idx == ID_W'(gi));
    end
  endgenerate

  assign grant_a = req_a[int'(grant_idx)*W +: W];
  assign grant_b = req_b[int'(grant_idx)*W +: W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : gen_interleave
      assign add_in[2*gi]   = grant_a[gi];
      assign add_in[2*gi+1] = grant_b[gi];
    end
  endgenerate

  BrentKung u_adder (
    .ab  (add_in),
    .sum (add_sum)
  );

  assign rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    count_next = count_reg;
    case ({grant, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      op_cnt_reg <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_reg[e] <= '0;
      end
    end else begin
      if (grant) begin
        // When full, wr_ptr equals rd_ptr: the new entry lands in the slot
        // being popped this cycle, so order is preserved.
        mem_reg[wr_ptr_reg] <= '{sum: add_sum, id: RES_ID_W'(grant_idx)};
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
        rr_ptr_reg          <= rr_ptr_next;
        op_cnt_reg          <= op_cnt_reg + 16'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign head    = mem_reg[rd_ptr_reg];
  assign res_sum = head.sum;
  assign res_id  = head.id[ID_W-1:0];
  assign op_cnt  = op_cnt_reg;

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

  localparam int N_REQ = 4;
  localparam int W     = 12;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic [W:0]         res_sum;
  logic [ID_W-1:0]    res_id;
  logic               res_ready;
  logic [15:0]        op_cnt;

  int checks = 0;
  int errors = 0;

  add_share_arb #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want %b", req_ready, 4'b0000); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if (res_sum !== 13'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", res_sum); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", res_id); end
    checks++; if (op_cnt !== 16'h0000) begin errors++; $display("FAIL reset_opcnt got %h want 0000", op_cnt); end
    $display("reset: ready=%b valid=%b op_cnt=%h", req_ready, res_valid, op_cnt);
    rst       = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0001;
    set_op(0, 12'h0FF, 12'h001);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", res_valid); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", res_valid); end
    checks++; if (res_sum !== 13'h0100) begin errors++; $display("FAIL single_sum got %h want 0100", res_sum); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", res_id); end
    checks++; if (op_cnt !== 16'd1) begin errors++; $display("FAIL single_opcnt got %0d want 1", op_cnt); end
    $display("single: id=%0d sum=%h op_cnt=%0d", res_id, res_sum, op_cnt);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", res_valid); end
  endtask

  task automatic test_carry();
    @(negedge clk);
    req_valid = 4'b0100;
    set_op(2, 12'hFFF, 12'hFFF);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_ready got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (res_sum !== 13'h1FFE) begin errors++; $display("FAIL carry_sum got %h want 1ffe", res_sum); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL carry_id got %0d want 2", res_id); end
    checks++; if (op_cnt !== 16'd2) begin errors++; $display("FAIL carry_opcnt got %0d want 2", op_cnt); end
    $display("carry: id=%0d sum=%h", res_id, res_sum);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [ID_W-1:0] exp_id [5];
    logic [W:0]      sum_tab [4];
    logic [ID_W-1:0] prev_id;
    logic [W:0]      prev_sum;
    logic [N_REQ-1:0] exp_ready;
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    sum_tab[0] = 13'h0579; sum_tab[1] = 13'h1000; sum_tab[2] = 13'h0BCD; sum_tab[3] = 13'h1001;
    set_op(0, 12'h123, 12'h456);
    set_op(1, 12'h800, 12'h800);
    set_op(2, 12'hABC, 12'h111);
    set_op(3, 12'hFFE, 12'h003);
    // rr_ptr is 3 here; one grant to requester 3 brings it back to 0.
    @(negedge clk);
    req_valid = 4'b1000;
    res_ready = 1'b1;
    @(posedge clk); #1;
    prev_id  = 2'd3;
    prev_sum = sum_tab[3];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      exp_ready = 4'b0001 << exp_id[k];
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_ready); end
      checks++; if (res_id !== prev_id) begin errors++; $display("FAIL rr_id[%0d] got %0d want %0d", k, res_id, prev_id); end
      checks++; if (res_sum !== prev_sum) begin errors++; $display("FAIL rr_sum[%0d] got %h want %h", k, res_sum, prev_sum); end
      $display("rr: grant=%b head_id=%0d head_sum=%h", req_ready, res_id, res_sum);
      @(posedge clk); #1;
      prev_id  = exp_id[k];
      prev_sum = sum_tab[exp_id[k]];
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rr_last_id got %0d want 0", res_id); end
    checks++; if (res_sum !== 13'h0579) begin errors++; $display("FAIL rr_last_sum got %h want 0579", res_sum); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", res_valid); end
    checks++; if (op_cnt !== 16'd8) begin errors++; $display("FAIL rr_opcnt got %0d want 8", op_cnt); end
  endtask

  task automatic test_backpressure();
    logic [N_REQ-1:0] exp_ready;
    int grants;
    grants    = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      if (c == 0) set_op(1, 12'h010, 12'h001);
      else if (c == 1) set_op(1, 12'h020, 12'h002);
      else set_op(1, 12'h030, 12'h003);
      #1;
      exp_ready = (c < 2) ? 4'b0010 : 4'b0000;
      if (req_ready[1]) grants++;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready[%0d] got %b want %b", c, req_ready, exp_ready); end
      if (c >= 1) begin
        checks++; if (res_sum !== 13'h0011) begin errors++; $display("FAIL bp_stable_sum[%0d] got %h want 0011", c, res_sum); end
        checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL bp_stable_id[%0d] got %0d want 1", c, res_id); end
      end
      $display("bp: cycle=%0d ready=%b head_sum=%h", c, req_ready, res_sum);
      @(posedge clk); #1;
    end
    checks++; if (grants !== 2) begin errors++; $display("FAIL bp_grants got %0d want 2", grants); end
    // Full FIFO plus a pop: one grant in the same cycle.
    @(negedge clk);
    res_ready = 1'b1;
    set_op(1, 12'h040, 12'h004);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_pop_grant got %b want 0010", req_ready); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 4'b0000;
    checks++; if (res_sum !== 13'h0022) begin errors++; $display("FAIL bp_order0 got %h want 0022", res_sum); end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_sum !== 13'h0044) begin errors++; $display("FAIL bp_order1 got %h want 0044", res_sum); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", res_valid); end
    checks++; if (op_cnt !== 16'd11) begin errors++; $display("FAIL bp_opcnt got %0d want 11", op_cnt); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    set_op(0, 12'h001, 12'h002);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_fill_ready got %b want 0001", req_ready); end
    @(posedge clk);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (op_cnt !== 16'd13) begin errors++; $display("FAIL mid_fill_opcnt got %0d want 13", op_cnt); end
    @(negedge clk);
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", res_valid); end
    checks++; if (op_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_opcnt got %0d want 0", op_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
    $display("mid reset: valid=%b op_cnt=%0d", res_valid, op_cnt);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL mid_first_id got %0d want 0", res_id); end
    checks++; if (res_sum !== 13'h0003) begin errors++; $display("FAIL mid_first_sum got %h want 0003", res_sum); end
    checks++; if (op_cnt !== 16'd1) begin errors++; $display("FAIL mid_first_opcnt got %0d want 1", op_cnt); end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 65535; i++) begin
      #1;
      if (req_ready !== 4'b0001) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    #1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_stream_stalls got %0d want 0", bad); end
    checks++; if (op_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h want ffff", op_cnt); end
    $display("wrap: op_cnt=%h after 65535 accepts", op_cnt);
    @(negedge clk);
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (op_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_rollover got %h want 0000", op_cnt); end
    $display("wrap: op_cnt=%h after one more accept", op_cnt);
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
